pc_source_ctrl: RTL and testbench

//  Sequential driver of the PC-source mux select (MuxPC) and the PC/EPC write enables.

---
 rtl/pc_source_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pc_source_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_source_ctrl.sv
// rtl/pc_source_ctrl.sv - PC-source mux select and PC/EPC write sequencer, with exception entry.
// Optional macro PC_STALL_EN adds a stall input that freezes sampling, the vector wait and the PC write.
module pc_source_ctrl #(
  parameter int VEC_WAIT = 2,
  parameter int SEL_W    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch,
  input  logic             redir_req,
  input  logic [1:0]       redir_kind,
  input  logic             exc,
  input  logic [1:0]       exc_cause,
`ifdef PC_STALL_EN
  input  logic             stall,
`endif
  output logic [SEL_W-1:0] mux_pc,
  output logic             pc_write,
  output logic             epc_write,
  output logic             vec_rd,
  output logic [1:0]       cause_q,
  output logic             busy
);

  if (VEC_WAIT < 1 || VEC_WAIT > 7) begin : g_vec_wait_range
    $error("pc_source_ctrl: VEC_WAIT must be in 1..7");
  end

  localparam logic [SEL_W-1:0] SEL_ALU  = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_EPC  = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_OFF  = SEL_W'(2);
  localparam logic [SEL_W-1:0] SEL_HOLD = SEL_W'(3);
  localparam logic [SEL_W-1:0] SEL_IMM  = SEL_W'(4);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PC_WR,
    ST_EXC_SAVE,
    ST_EXC_REQ,
    ST_EXC_WAIT,
    ST_EXC_LOAD
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [1:0]       cause_d;
  logic [SEL_W-1:0] mux_d;
  logic             pcw_d, epcw_d, vec_d, busy_d;
  logic             stall_i;
  logic [SEL_W-1:0] redir_sel;

`ifdef PC_STALL_EN
  assign stall_i = stall;
`else
  assign stall_i = 1'b0;
`endif

  always_comb begin
    redir_sel = SEL_HOLD;
    case (redir_kind)
      2'd0: redir_sel = SEL_ALU;
      2'd1: redir_sel = SEL_EPC;
      2'd2: redir_sel = SEL_OFF;
      2'd3: redir_sel = SEL_IMM;
      default: redir_sel = SEL_HOLD;
    endcase
  end

  // Outputs are computed for the state being entered and registered with it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    mux_d   = SEL_HOLD;
    pcw_d   = 1'b0;
    epcw_d  = 1'b0;
    vec_d   = 1'b0;
    busy_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!stall_i) begin
          if (exc) begin
            state_d = ST_EXC_SAVE;
            cause_d = exc_cause;
            epcw_d  = 1'b1;
            busy_d  = 1'b1;
          end else if (redir_req) begin
            state_d = ST_PC_WR;
            mux_d   = redir_sel;
            pcw_d   = 1'b1;
          end else if (fetch) begin
            state_d = ST_PC_WR;
            mux_d   = SEL_ALU;
            pcw_d   = 1'b1;
          end
        end
      end
      ST_PC_WR: begin
        if (!pc_write) begin
          mux_d = mux_pc;
          pcw_d = !stall_i;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXC_SAVE: begin
        state_d = ST_EXC_REQ;
        vec_d   = 1'b1;
        busy_d  = 1'b1;
        cnt_d   = 3'(VEC_WAIT - 1);
      end
      ST_EXC_REQ: begin
        state_d = ST_EXC_WAIT;
        busy_d  = 1'b1;
      end
      ST_EXC_WAIT: begin
        busy_d = 1'b1;
        // At least one wait cycle, even when the vector arrives one cycle after the request.
        if (!stall_i) begin
          if (cnt_q <= 3'd1) begin
            state_d = ST_EXC_LOAD;
            mux_d   = SEL_OFF;
            pcw_d   = 1'b1;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      ST_EXC_LOAD: begin
        if (!pc_write) begin
          mux_d  = SEL_OFF;
          pcw_d  = !stall_i;
          busy_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      cause_q   <= 2'd0;
      mux_pc    <= SEL_HOLD;
      pc_write  <= 1'b0;
      epc_write <= 1'b0;
      vec_rd    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cause_q   <= cause_d;
      mux_pc    <= mux_d;
      pc_write  <= pcw_d;
      epc_write <= epcw_d;
      vec_rd    <= vec_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_pc_source_ctrl.sv
// tb/tb_pc_source_ctrl.sv - self-checking bench for pc_source_ctrl: vector table, corner sequences, random vs model.
module tb_pc_source_ctrl;
  localparam int VW = 2;
  localparam int N  = 400;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fetch = 1'b0, redir_req = 1'b0, exc = 1'b0;
  logic [1:0] redir_kind = 2'd0, exc_cause = 2'd0;
`ifdef PC_STALL_EN
  logic stall = 1'b0;
`endif
  logic [2:0] mux_pc;
  logic pc_write, epc_write, vec_rd, busy;
  logic [1:0] cause_q;

  int total = 0;
  int passed = 0;

  pc_source_ctrl #(.VEC_WAIT(VW), .SEL_W(3)) dut (
    .clk(clk), .reset(reset), .fetch(fetch), .redir_req(redir_req),
    .redir_kind(redir_kind), .exc(exc), .exc_cause(exc_cause),
`ifdef PC_STALL_EN
    .stall(stall),
`endif
    .mux_pc(mux_pc), .pc_write(pc_write), .epc_write(epc_write),
    .vec_rd(vec_rd), .cause_q(cause_q), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic f; logic r; logic [1:0] k; logic e; logic [1:0] c;
    int mux; int pcw; int epc; int bsy;
  } vec_t;
  vec_t vt[8];

  int e_mux[N+16], e_pcw[N+16], e_epc[N+16], e_vec[N+16], e_busy[N+16], e_cause[N+16];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic idle_in();
    fetch = 1'b0; redir_req = 1'b0; exc = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic int kind_sel(input int k);
    return (k == 3) ? 4 : k;
  endfunction

  initial begin
    int next_free;
    // fetch, redir, kind, exc, cause, mux, pcw, epc, busy
    vt[0] = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 0, 1, 0, 0};
    vt[1] = '{1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 4, 1, 0, 0};
    vt[2] = '{1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 1, 1, 0, 0};
    vt[3] = '{1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 2, 1, 0, 0};
    vt[4] = '{1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 0, 1, 0, 0};
    vt[5] = '{1'b0, 1'b0, 2'd0, 1'b1, 2'd3, 3, 0, 1, 1};
    vt[6] = '{1'b1, 1'b1, 2'd2, 1'b1, 2'd1, 3, 0, 1, 1};
    vt[7] = '{1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 3, 0, 0, 0};

    #12;
    chk("reset_mux", mux_pc, 3);
    chk("reset_pcw", pc_write, 0);
    chk("reset_busy", busy, 0);
    chk("reset_cause", cause_q, 0);
    tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      fetch = vt[i].f; redir_req = vt[i].r; redir_kind = vt[i].k;
      exc = vt[i].e; exc_cause = vt[i].c;
      tick();
      idle_in();
      chk($sformatf("vec%0d_mux", i), mux_pc, vt[i].mux);
      chk($sformatf("vec%0d_pcw", i), pc_write, vt[i].pcw);
      chk($sformatf("vec%0d_epc", i), epc_write, vt[i].epc);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].bsy);
      if (vt[i].e) chk($sformatf("vec%0d_cause", i), cause_q, vt[i].c);
      tick();
      chk($sformatf("vec%0d_pcw_next", i), pc_write, 0);
      if (!vt[i].e) chk($sformatf("vec%0d_mux_next", i), mux_pc, 3);
      repeat (8) tick();
    end

    // Exception entry timeline, cause 2
    exc = 1'b1; exc_cause = 2'd2;
    for (int k = 1; k <= 6; k++) begin
      tick();
      idle_in();
      chk($sformatf("exc_t%0d_epc", k), epc_write, int'(k == 1));
      chk($sformatf("exc_t%0d_vec", k), vec_rd, int'(k == 2));
      chk($sformatf("exc_t%0d_pcw", k), pc_write, int'(k == 4));
      chk($sformatf("exc_t%0d_mux", k), mux_pc, (k == 4) ? 2 : 3);
      chk($sformatf("exc_t%0d_busy", k), busy, int'(k <= 4));
      chk($sformatf("exc_t%0d_cause", k), cause_q, 2);
    end

    // Priority plus inputs ignored while busy; nested exc keeps cause
    exc = 1'b1; exc_cause = 2'd3; fetch = 1'b1; redir_req = 1'b1; redir_kind = 2'd1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      redir_req = 1'b0;
      fetch = (k < 3);
      exc = (k == 2);
      exc_cause = 2'd1;
      chk($sformatf("busy_t%0d_pcw", k), pc_write, int'(k == 4));
      chk($sformatf("busy_t%0d_busy", k), busy, int'(k <= 4));
      chk($sformatf("busy_t%0d_cause", k), cause_q, 3);
    end
    idle_in();
    repeat (3) tick();

    // Eret redirect leaves cause untouched
    redir_req = 1'b1; redir_kind = 2'd1;
    tick();
    idle_in();
    chk("eret_mux", mux_pc, 1);
    chk("eret_cause", cause_q, 3);
    repeat (2) tick();

`ifdef PC_STALL_EN
    exc = 1'b1; exc_cause = 2'd1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      idle_in();
      if (k == 3) stall = 1'b1;
      if (k == 6) stall = 1'b0;
      chk($sformatf("stall_t%0d_pcw", k), pc_write, int'(k == 7));
      chk($sformatf("stall_t%0d_busy", k), busy, int'(k <= 7));
    end
    repeat (2) tick();
`endif

    // Asynchronous reset in the middle of the vector wait
    exc = 1'b1; exc_cause = 2'd1;
    repeat (3) tick();
    idle_in();
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_cause", cause_q, 1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_mux", mux_pc, 3);
    chk("midrst_pcw", pc_write, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cause", cause_q, 0);
    tick();
    reset = 1'b0;

    // Randomized run against a schedule-based model
    for (int n = 0; n < N + 16; n++) begin
      e_mux[n] = 3; e_pcw[n] = 0; e_epc[n] = 0; e_vec[n] = 0; e_busy[n] = 0; e_cause[n] = 0;
    end
    next_free = 0;
    for (int n = 0; n < N; n++) begin
      tick();
      chk("rnd_mux", mux_pc, e_mux[n]);
      chk("rnd_pcw", pc_write, e_pcw[n]);
      chk("rnd_epc", epc_write, e_epc[n]);
      chk("rnd_vec", vec_rd, e_vec[n]);
      chk("rnd_busy", busy, e_busy[n]);
      chk("rnd_cause", cause_q, e_cause[n]);
      exc = ($urandom_range(0, 7) == 0);
      redir_req = ($urandom_range(0, 3) == 0);
      fetch = $urandom_range(0, 1) != 0;
      redir_kind = 2'($urandom_range(0, 3));
      exc_cause = 2'($urandom_range(0, 3));
      e_cause[n+1] = e_cause[n];
      if (n >= next_free) begin
        if (exc) begin
          for (int k = 1; k <= 2 + VW; k++) e_busy[n+k] = 1;
          e_epc[n+1] = 1;
          e_vec[n+2] = 1;
          e_mux[n+2+VW] = 2;
          e_pcw[n+2+VW] = 1;
          e_cause[n+1] = exc_cause;
          next_free = n + 3 + VW;
        end else if (redir_req) begin
          e_mux[n+1] = kind_sel(int'(redir_kind));
          e_pcw[n+1] = 1;
          next_free = n + 2;
        end else if (fetch) begin
          e_mux[n+1] = 0;
          e_pcw[n+1] = 1;
          next_free = n + 2;
        end
      end
    end
    idle_in();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
